// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between the CPU
// load/store path and the video fetch engine. One access is in flight at a
// time. Video has priority, and a starvation counter bounds how many video
// grants the CPU can lose in a row before it is forced through.
module ram_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        owner
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_VID  = 2'b10
    } owner_t;

    state_t             state_q, state_d;
    owner_t             owner_q, owner_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               op_we_q, op_we_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
    logic               ram_we_q, ram_we_d;
    logic               cpu_ack_q, cpu_ack_d;
    logic               vid_ack_q, vid_ack_d;
    logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]  vid_rdata_q, vid_rdata_d;

    logic               grant_cpu;
    logic               grant_vid;

    // Arbitration: video wins a tie unless the CPU has been starved STARVE_MAX times.
    always_comb begin
        grant_cpu = cpu_req && (!vid_req || (starve_q == STARVE_LIM));
        grant_vid = vid_req && !grant_cpu;
    end

    // State register and all registered outputs; reset aborts any access in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            starve_q    <= '0;
            op_we_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            op_we_q     <= op_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_ack_q   <= vid_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
        end
    end

    // Next-state: IDLE waits for a request, the other three states last one cycle each.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (cpu_req || vid_req) state_d = S_ADDR;
            S_ADDR: state_d = S_WAIT;
            S_WAIT: state_d = S_ACK;
            S_ACK:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values: grant and RAM drive in IDLE, ack and read capture in WAIT.
    always_comb begin
        owner_d     = owner_q;
        starve_d    = starve_q;
        op_we_d     = op_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        vid_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant_cpu) begin
                    owner_d     = OWN_CPU;
                    starve_d    = '0;
                    op_we_d     = cpu_we;
                    ram_addr_d  = cpu_addr;
                    ram_wdata_d = cpu_wdata;
                    ram_we_d    = cpu_we;
                end else if (grant_vid) begin
                    owner_d    = OWN_VID;
                    op_we_d    = 1'b0;
                    ram_addr_d = vid_addr;
                    if (!cpu_req) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_LIM) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end
            end
            S_ADDR: begin
                // RAM samples address (and write) on this edge; ram_we drops via default.
            end
            S_WAIT: begin
                if (owner_q == OWN_CPU) begin
                    cpu_ack_d = 1'b1;
                    if (!op_we_q) cpu_rdata_d = ram_rdata;
                end else if (owner_q == OWN_VID) begin
                    vid_ack_d   = 1'b1;
                    vid_rdata_d = ram_rdata;
                end
            end
            S_ACK: begin
                owner_d = OWN_NONE;
            end
            default: begin
                owner_d = OWN_NONE;
            end
        endcase
    end

    assign cpu_ack   = cpu_ack_q;
    assign vid_ack   = vid_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vid_rdata = vid_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed stimulus pushes expected acks
// (who, cycle, read data) into a queue; a negedge monitor pops and compares.
module tb_ram_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        vid_req = 1'b0;
    logic [15:0] vid_addr = '0;
    logic        vid_ack;
    logic [15:0] vid_rdata;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata = '0;
    logic [1:0]  owner;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        bit          is_cpu;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    ram_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(4)) dut (
        .CLK(CLK), .RST(RST),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .owner(owner)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // RAM model: unwritten locations read as addr ^ 16'h5A5A
    logic [15:0] mem [0:65535];
    bit          wr  [0:65535];
    always @(posedge CLK) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr[ram_addr]  <= 1'b1;
        end
        ram_rdata <= wr[ram_addr] ? mem[ram_addr] : (ram_addr ^ 16'h5A5A);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cyc %0d: actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input bit is_cpu, input logic [15:0] rdata, input int at);
        exp_t e;
        e.is_cpu = is_cpu;
        e.rdata  = rdata;
        e.cyc    = at;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each ack
    always @(negedge CLK) begin
        chk("owner_legal", 32'(owner == 2'b11), 32'd0);
        chk("acks_exclusive", 32'(cpu_ack && vid_ack), 32'd0);
        if (cpu_ack || vid_ack) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack at cyc %0d: actual cpu_ack=%0b vid_ack=%0b expected none",
                         cyc, cpu_ack, vid_ack);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_who_cpu", 32'(cpu_ack), 32'(e.is_cpu));
                chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                chk("ack_rdata", 32'(cpu_ack ? cpu_rdata : vid_rdata), 32'(e.rdata));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;

        // Reset state
        step(3);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_vid_ack", 32'(vid_ack), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_vid_rdata", 32'(vid_rdata), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_starve", 32'(dut.starve_q), 32'd0);
        RST = 1'b0;
        step(2);

        // 1: CPU write 0xBEEF to 0x0010
        c = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
        push(1'b1, 16'h0000, c + 3);
        step(1);
        chk("t1_ram_we_hi", 32'(ram_we), 32'd1);
        chk("t1_ram_addr", 32'(ram_addr), 32'h0010);
        chk("t1_ram_wdata", 32'(ram_wdata), 32'hBEEF);
        chk("t1_owner_cpu", 32'(owner), 32'd1);
        step(1);
        chk("t1_ram_we_lo", 32'(ram_we), 32'd0);
        step(1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        step(1);
        chk("t1_owner_idle", 32'(owner), 32'd0);
        chk("t1_ram_addr_held", 32'(ram_addr), 32'h0010);
        step(1);

        // 2: CPU read-back of 0x0010
        c = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        push(1'b1, 16'hBEEF, c + 3);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("t2_ram_we_lo", 32'(ram_we), 32'd0);
        end
        cpu_req = 1'b0;
        step(2);

        // 3: simultaneous requests, video first
        c = cyc;
        cpu_req = 1'b1; cpu_addr = 16'h0010;
        vid_req = 1'b1; vid_addr = 16'h0020;
        push(1'b0, 16'h5A7A, c + 3);
        push(1'b1, 16'hBEEF, c + 7);
        step(1);
        chk("t3_owner_vid", 32'(owner), 32'd2);
        chk("t3_ram_addr_vid", 32'(ram_addr), 32'h0020);
        step(2);
        vid_req = 1'b0;
        step(2);
        chk("t3_owner_cpu", 32'(owner), 32'd1);
        step(2);
        cpu_req = 1'b0;
        step(2);

        // 4: starvation, both held: V,V,V,V,C,V,V,V,V,C
        c = cyc;
        cpu_req = 1'b1; cpu_addr = 16'h0010;
        vid_req = 1'b1; vid_addr = 16'h0020;
        for (int i = 0; i < 10; i++) begin
            bit is_c;
            is_c = (i == 4) || (i == 9);
            push(is_c, is_c ? 16'hBEEF : 16'h5A7A, c + 3 + 4 * i);
        end
        for (int i = 0; i < 10; i++) begin
            bit is_c;
            is_c = (i == 4) || (i == 9);
            if (i == 0 || i == 4 || i == 5 || i == 9)
                chk("t4_starve_before_grant", 32'(dut.starve_q), is_c ? 32'd4 : 32'd0);
            step(1);
            chk("t4_grant_owner", 32'(owner), is_c ? 32'd1 : 32'd2);
            step(3);
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        step(2);

        // 5: reset during WAIT of a video read
        c = cyc;
        vid_req = 1'b1; vid_addr = 16'h0030;
        step(2);
        RST = 1'b1;
        step(1);
        chk("t5_owner_after_rst", 32'(owner), 32'd0);
        chk("t5_vid_ack_after_rst", 32'(vid_ack), 32'd0);
        chk("t5_state_idle", 32'(dut.state_q), 32'd0);
        RST = 1'b0;
        push(1'b0, 16'h5A6A, cyc + 3);
        step(3);
        vid_req = 1'b0;
        step(2);

        // 6: back-to-back CPU reads with req held
        c = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        push(1'b1, 16'h5A1A, c + 3);
        push(1'b1, 16'h5A0A, c + 7);
        step(1);
        chk("t6_ram_addr_first", 32'(ram_addr), 32'h0040);
        step(2);
        cpu_addr = 16'h0050;
        step(1);
        chk("t6_ram_addr_hold", 32'(ram_addr), 32'h0040);
        step(1);
        chk("t6_ram_addr_next", 32'(ram_addr), 32'h0050);
        step(2);
        cpu_req = 1'b0;
        step(4);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
